// File: rtl/three_zone_seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package three_zone_div_pkg;
  localparam int DIVIDEND_W = 32;
  localparam int DIVISOR_W  = 16;
  localparam int QUOT_W     = 32;

  // Quotient reported when the divisor is zero
  localparam logic [QUOT_W-1:0] DBZ_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;
endpackage

// File: rtl/three_zone_seq_divider_if.sv
// Operand/result handshake bundle for the sequential divider.
interface three_zone_seq_divider_if;
  import three_zone_div_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [QUOT_W-1:0]     quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  // Requester / result consumer side
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  // Divider side
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/three_zone_seq_divider_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract.
module div_restore_step
  import three_zone_div_pkg::*;
(
  input  logic [DIVISOR_W:0]   rem_i,
  input  logic                 dvd_bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W:0]   rem_o,
  output logic                 quot_bit_o
);
  logic [DIVISOR_W:0] rem_shift;
  logic [DIVISOR_W:0] dvs_ext;
  logic               unused_rem_msb;

  // The partial remainder is always below the divisor, so its top bit is
  // zero and dropping it in the shift loses nothing.
  assign unused_rem_msb = rem_i[DIVISOR_W];
  assign rem_shift      = {rem_i[DIVISOR_W-1:0], dvd_bit_i};
  assign dvs_ext        = {1'b0, divisor_i};

  // Trial subtraction; keep the shifted value when it would go negative
  always_comb begin
    quot_bit_o = (rem_shift >= dvs_ext);
    rem_o      = quot_bit_o ? (rem_shift - dvs_ext) : rem_shift;
  end
endmodule

// File: rtl/three_zone_seq_divider.sv
// Iterative restoring divider, 32/16 -> 32 quotient + 16 remainder.
// APPROX_LSB skips the final iterations; those quotient bits read as zero.
module three_zone_seq_divider
  import three_zone_div_pkg::*;
#(
  parameter int APPROX_LSB = 0
) (
  input logic                     clk,
  input logic                     rst_n,
  three_zone_seq_divider_if.slave bus
);
  localparam int ITERS = QUOT_W - APPROX_LSB;
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

  if (APPROX_LSB < 0 || APPROX_LSB > 16) begin : g_bad_approx
    $error("APPROX_LSB must lie in 0..16");
  end

  state_t                state_q, state_d;
  logic [DIVIDEND_W-1:0] dvd_q,   dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q,   dvs_d;
  logic [DIVISOR_W:0]    rem_q,   rem_d;
  logic [QUOT_W-1:0]     acc_q,   acc_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [QUOT_W-1:0]     quot_q,  quot_d;
  logic [DIVISOR_W-1:0]  remout_q, remout_d;
  logic                  dbz_q,   dbz_d;

  logic [DIVISOR_W:0]    rem_step;
  logic                  quot_bit;

  div_restore_step u_step (
    .rem_i      (rem_q),
    .dvd_bit_i  (dvd_q[DIVIDEND_W-1]),
    .divisor_i  (dvs_q),
    .rem_o      (rem_step),
    .quot_bit_o (quot_bit)
  );

  // Next-state: accept in IDLE, iterate MSB-first in RUN, hold results in DONE.
  // A zero divisor still passes through RUN for one cycle so its result
  // appears one edge after the accept.
  always_comb begin
    state_d  = state_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    quot_d   = quot_q;
    remout_d = remout_q;
    dbz_d    = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          dvd_d   = bus.dividend;
          dvs_d   = bus.divisor;
          rem_d   = '0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (dvs_q == '0) begin
          quot_d   = DBZ_QUOT;
          remout_d = dvd_q[DIVISOR_W-1:0];
          dbz_d    = 1'b1;
          state_d  = DONE;
        end else begin
          dvd_d = dvd_q << 1;
          rem_d = rem_step;
          acc_d = (acc_q << 1) | QUOT_W'(quot_bit);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            quot_d   = acc_d << APPROX_LSB;
            remout_d = rem_step[DIVISOR_W-1:0];
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          dbz_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      quot_q   <= '0;
      remout_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      quot_q   <= quot_d;
      remout_q <= remout_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = remout_q;
  assign bus.div_by_zero = dbz_q;
endmodule
